// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, 2-FF line synchronizer, start-bit glitch rejection, mid-bit sampling.
// Latency: o_valid rises HALF+9*BIT_CNT+3 clocks after the start-bit falling edge at the pin.
// Backpressure: none; o_valid/o_frame_err are single-cycle pulses the consumer must take as they come.
module uart_rx #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_uart_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int BIT_CNT = CLK_FREQ / BAUD;
  localparam int HALF    = BIT_CNT / 2;
  localparam int CNT_W   = (BIT_CNT > 1) ? $clog2(BIT_CNT) : 1;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CNT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic             rx_meta;
  logic             rx_sync;
  logic             rx_prev;
  logic             rx_fall;
  logic [1:0]       state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;

  // Two-stage synchronizer plus a delayed copy for edge detection; all reset to the idle-high level
  // so that a line already low at reset release looks like a fresh start bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= i_uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall = rx_prev & ~rx_sync;

  // Frame FSM: locate the start-bit middle, then sample each following bit one bit-time apart.
  // Returning to IDLE at the stop-bit middle leaves half a bit to catch a directly following start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      baud_cnt    <= '0;
      bit_idx     <= '0;
      shift_reg   <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_fall) begin
            state    <= START;
            baud_cnt <= '0;
          end
        end
        START: begin
          if (baud_cnt == HALF_LAST) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            // A line that is high again at mid start bit was only a glitch.
            state    <= rx_sync ? IDLE : DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt           <= '0;
            shift_reg[bit_idx] <= rx_sync;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            state    <= IDLE;
            if (rx_sync) begin
              o_data  <= shift_reg;
              o_valid <= 1'b1;
            end else begin
              // Bad stop bit: keep the last good byte on o_data.
              o_frame_err <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          baud_cnt <= '0;
        end
      endcase
    end
  end

  assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives serial frames into uart_rx and checks decoded bytes, error pulses and timing.
// Expected results come from the frame contents and bit-time arithmetic, not from DUT internals.
// Events are captured by a monitor on the falling clock edge and compared per scenario.
module tb_uart_rx;

  localparam int CLK_FREQ = 50000000;
  localparam int BAUD     = 115200;
  localparam int BIT_CNT  = CLK_FREQ / BAUD;
  localparam int HALF     = BIT_CNT / 2;
  localparam int LAT      = HALF + 9 * BIT_CNT + 3;
  localparam int FRAME    = 10 * BIT_CNT;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx    = 1'b1;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int both_cnt = 0;

  int         v_cyc[$];
  logic [7:0] v_dat[$];
  int         e_cyc[$];
  int         fall_q[$];
  logic [7:0] last_good;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_uart_rx  (rx),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_frame_err(o_frame_err),
    .o_busy     (o_busy)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every high cycle of a pulse is logged, so a stretched pulse shows up as an extra event.
  always @(negedge clk) begin
    if (o_valid === 1'b1) begin
      v_cyc.push_back(cyc);
      v_dat.push_back(o_data);
    end
    if (o_frame_err === 1'b1) e_cyc.push_back(cyc);
    if (o_valid === 1'b1 && o_frame_err === 1'b1) both_cnt++;
  end

  task automatic clear_events();
    v_cyc.delete();
    v_dat.delete();
    e_cyc.delete();
    fall_q.delete();
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Serialises one frame; must be entered right after a falling clock edge.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    fall_q.push_back(cyc);
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (BIT_CNT) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++; if (o_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", o_data); end
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
    n_checks++; if (o_frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b expected 0", o_frame_err); end
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
    rst_n = 1'b1;
    idle_bits(20);
    last_good = 8'h00;
  endtask

  task automatic test_single();
    int lat;
    clear_events();
    send_frame(8'h3D, 1'b1);
    idle_bits(BIT_CNT);
    last_good = 8'h3D;
    lat = (v_cyc.size() > 0) ? v_cyc[0] - fall_q[0] : -1;
    n_checks++; if (v_cyc.size() != 1) begin n_fail++; $display("FAIL single_vcount: got %0d expected 1", v_cyc.size()); end
    n_checks++; if (((v_dat.size() > 0) ? v_dat[0] : 8'hxx) !== 8'h3D) begin n_fail++; $display("FAIL single_data: got %h expected 3d", (v_dat.size() > 0) ? v_dat[0] : 8'hxx); end
    n_checks++; if (lat < LAT - 1 || lat > LAT + 1) begin n_fail++; $display("FAIL single_latency: got %0d expected %0d+/-1", lat, LAT); end
    n_checks++; if (e_cyc.size() != 0) begin n_fail++; $display("FAIL single_ferr: got %0d pulses expected 0", e_cyc.size()); end
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b expected 0", o_busy); end
    n_checks++; if (o_data !== 8'h3D) begin n_fail++; $display("FAIL single_hold: got %h expected 3d", o_data); end
  endtask

  task automatic test_back_to_back();
    int gap;
    clear_events();
    send_frame(8'h55, 1'b1);
    send_frame(8'hAA, 1'b1);
    idle_bits(BIT_CNT);
    last_good = 8'hAA;
    gap = (v_cyc.size() > 1) ? v_cyc[1] - v_cyc[0] : -1;
    n_checks++; if (v_cyc.size() != 2) begin n_fail++; $display("FAIL b2b_vcount: got %0d expected 2", v_cyc.size()); end
    n_checks++; if (((v_dat.size() > 0) ? v_dat[0] : 8'hxx) !== 8'h55) begin n_fail++; $display("FAIL b2b_data0: got %h expected 55", (v_dat.size() > 0) ? v_dat[0] : 8'hxx); end
    n_checks++; if (((v_dat.size() > 1) ? v_dat[1] : 8'hxx) !== 8'hAA) begin n_fail++; $display("FAIL b2b_data1: got %h expected aa", (v_dat.size() > 1) ? v_dat[1] : 8'hxx); end
    n_checks++; if (gap < FRAME - 2 || gap > FRAME + 2) begin n_fail++; $display("FAIL b2b_gap: got %0d expected %0d+/-2", gap, FRAME); end
    n_checks++; if (e_cyc.size() != 0) begin n_fail++; $display("FAIL b2b_ferr: got %0d pulses expected 0", e_cyc.size()); end
  endtask

  task automatic test_glitch();
    int busy_cnt;
    clear_events();
    busy_cnt = 0;
    rx = 1'b0;
    for (int i = 0; i < 700; i++) begin
      if (i == 100) rx = 1'b1;
      @(negedge clk);
      if (o_busy === 1'b1) busy_cnt++;
    end
    n_checks++; if (v_cyc.size() != 0) begin n_fail++; $display("FAIL glitch_valid: got %0d pulses expected 0", v_cyc.size()); end
    n_checks++; if (e_cyc.size() != 0) begin n_fail++; $display("FAIL glitch_ferr: got %0d pulses expected 0", e_cyc.size()); end
    n_checks++; if (busy_cnt < HALF - 3 || busy_cnt > HALF + 3) begin n_fail++; $display("FAIL glitch_busy_len: got %0d expected %0d+/-3", busy_cnt, HALF); end
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_end: got %b expected 0", o_busy); end
  endtask

  task automatic test_frame_err();
    int lat;
    clear_events();
    send_frame(8'hA5, 1'b0);
    idle_bits(BIT_CNT);
    lat = (e_cyc.size() > 0) ? e_cyc[0] - fall_q[0] : -1;
    n_checks++; if (e_cyc.size() != 1) begin n_fail++; $display("FAIL ferr_count: got %0d expected 1", e_cyc.size()); end
    n_checks++; if (v_cyc.size() != 0) begin n_fail++; $display("FAIL ferr_valid: got %0d pulses expected 0", v_cyc.size()); end
    n_checks++; if (o_data !== last_good) begin n_fail++; $display("FAIL ferr_hold: got %h expected %h", o_data, last_good); end
    n_checks++; if (lat < LAT - 1 || lat > LAT + 1) begin n_fail++; $display("FAIL ferr_latency: got %0d expected %0d+/-1", lat, LAT); end
  endtask

  task automatic test_break();
    logic busy_late;
    clear_events();
    rx = 1'b0;
    repeat (15 * BIT_CNT) @(negedge clk);
    busy_late = o_busy;
    idle_bits(BIT_CNT);
    n_checks++; if (e_cyc.size() != 1) begin n_fail++; $display("FAIL break_ferr: got %0d pulses expected 1", e_cyc.size()); end
    n_checks++; if (v_cyc.size() != 0) begin n_fail++; $display("FAIL break_valid: got %0d pulses expected 0", v_cyc.size()); end
    n_checks++; if (busy_late !== 1'b0) begin n_fail++; $display("FAIL break_retrigger: busy %b expected 0", busy_late); end
    n_checks++; if (o_data !== last_good) begin n_fail++; $display("FAIL break_hold: got %h expected %h", o_data, last_good); end
  endtask

  task automatic test_reset_mid_frame();
    logic       busy_before;
    logic       busy_rst;
    logic [7:0] data_rst;
    clear_events();
    busy_before = 1'b0;
    busy_rst    = 1'bx;
    data_rst    = 8'hxx;
    // Bits 3..7 of 0xF9 are 1, so the line stays high after reset release: no stray start edge.
    fork
      send_frame(8'hF9, 1'b1);
      begin
        repeat (4 * BIT_CNT + HALF) @(negedge clk);
        busy_before = o_busy;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        busy_rst = o_busy;
        data_rst = o_data;
        rst_n = 1'b1;
      end
    join
    idle_bits(BIT_CNT);
    last_good = 8'h00;
    n_checks++; if (busy_before !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_before: got %b expected 1", busy_before); end
    n_checks++; if (busy_rst !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy_rst); end
    n_checks++; if (data_rst !== 8'h00) begin n_fail++; $display("FAIL rstmid_data: got %h expected 00", data_rst); end
    n_checks++; if (v_cyc.size() + e_cyc.size() != 0) begin n_fail++; $display("FAIL rstmid_pulses: got %0d expected 0", v_cyc.size() + e_cyc.size()); end
    clear_events();
    send_frame(8'h81, 1'b1);
    idle_bits(BIT_CNT);
    last_good = 8'h81;
    n_checks++; if (v_cyc.size() != 1) begin n_fail++; $display("FAIL rstmid_next_count: got %0d expected 1", v_cyc.size()); end
    n_checks++; if (o_data !== 8'h81) begin n_fail++; $display("FAIL rstmid_next_data: got %h expected 81", o_data); end
  endtask

  // Bench-side serializer stands in for a uart_tx with the same bit timing.
  task automatic test_loopback();
    logic [7:0] pat [2];
    pat[0] = 8'h00;
    pat[1] = 8'hFF;
    for (int k = 0; k < 2; k++) begin
      clear_events();
      send_frame(pat[k], 1'b1);
      idle_bits(BIT_CNT);
      last_good = pat[k];
      n_checks++; if (v_cyc.size() != 1) begin n_fail++; $display("FAIL loop_count[%0d]: got %0d expected 1", k, v_cyc.size()); end
      n_checks++; if (((v_dat.size() > 0) ? v_dat[0] : 8'hxx) !== pat[k]) begin n_fail++; $display("FAIL loop_data[%0d]: got %h expected %h", k, (v_dat.size() > 0) ? v_dat[0] : 8'hxx, pat[k]); end
      n_checks++; if (e_cyc.size() != 0) begin n_fail++; $display("FAIL loop_ferr[%0d]: got %0d expected 0", k, e_cyc.size()); end
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_dat[$];
    int         exp_fall[$];
    int         exp_err;
    logic [7:0] b;
    logic       st;
    int         lat;
    clear_events();
    exp_err = 0;
    for (int k = 0; k < 3; k++) begin
      b  = 8'($urandom_range(0, 255));
      st = ($urandom_range(0, 3) != 0);
      send_frame(b, st);
      if (st) begin
        exp_dat.push_back(b);
        exp_fall.push_back(fall_q[fall_q.size() - 1]);
        last_good = b;
        idle_bits($urandom_range(0, 40));
      end else begin
        exp_err++;
        idle_bits(BIT_CNT);
      end
    end
    idle_bits(BIT_CNT);
    n_checks++; if (v_cyc.size() != exp_dat.size()) begin n_fail++; $display("FAIL rand_vcount: got %0d expected %0d", v_cyc.size(), exp_dat.size()); end
    n_checks++; if (e_cyc.size() != exp_err) begin n_fail++; $display("FAIL rand_ecount: got %0d expected %0d", e_cyc.size(), exp_err); end
    for (int i = 0; i < exp_dat.size(); i++) begin
      lat = (i < v_cyc.size()) ? v_cyc[i] - exp_fall[i] : -1;
      n_checks++; if (((i < v_dat.size()) ? v_dat[i] : 8'hxx) !== exp_dat[i]) begin n_fail++; $display("FAIL rand_data[%0d]: got %h expected %h", i, (i < v_dat.size()) ? v_dat[i] : 8'hxx, exp_dat[i]); end
      n_checks++; if (lat < LAT - 1 || lat > LAT + 1) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d expected %0d+/-1", i, lat, LAT); end
    end
    n_checks++; if (o_data !== last_good) begin n_fail++; $display("FAIL rand_hold: got %h expected %h", o_data, last_good); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_break();
    test_reset_mid_frame();
    test_loopback();
    test_random();
    n_checks++; if (both_cnt != 0) begin n_fail++; $display("FAIL valid_and_ferr_together: got %0d cycles expected 0", both_cnt); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
